// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: core writeback vs. buffered multi-cycle results,
// with a busy scoreboard, hazard/stall outputs and a forced drain when the FIFO starves.
module rf_wb_arbiter #(
    parameter int unsigned REG_DATA_WIDTH  = 32,
    parameter int unsigned REG_CODE_LENGTH = 5,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       core_we,
    input  logic [REG_CODE_LENGTH-1:0] core_rd,
    input  logic [REG_DATA_WIDTH-1:0]  core_wdata,
    input  logic [REG_CODE_LENGTH-1:0] rs1,
    input  logic [REG_CODE_LENGTH-1:0] rs2,
    output logic                       wb_stall,
    output logic                       hazard_stall,
    input  logic                       issue_valid,
    input  logic [REG_CODE_LENGTH-1:0] issue_rd,
    output logic                       issue_ready,
    input  logic                       mu_valid,
    input  logic [REG_CODE_LENGTH-1:0] mu_rd,
    input  logic [REG_DATA_WIDTH-1:0]  mu_wdata,
    output logic                       mu_ready,
    output logic                       RegWrite,
    output logic [REG_CODE_LENGTH-1:0] w_rg,
    output logic [REG_DATA_WIDTH-1:0]  w_data
);
    localparam int unsigned NREG = 2 ** REG_CODE_LENGTH;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, FORCE_DRAIN} state_t;

    state_t                     state, state_next;
    logic [CW-1:0]              starve_cnt, starve_next;
    logic [REG_CODE_LENGTH-1:0] fifo_rd   [FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [PW:0]                count;
    logic [NREG-1:0]            busy, busy_next;

    logic                       empty, full, core_win, pop, push, issue_fire;
    logic [REG_CODE_LENGTH-1:0] head_rd;
    logic [REG_DATA_WIDTH-1:0]  head_data;

    assign empty     = (count == '0);
    assign full      = (count == (PW + 1)'(FIFO_DEPTH));
    assign core_win  = core_we && (core_rd != '0);
    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    // In FORCE_DRAIN the head goes out regardless of the core request.
    assign pop        = !rst && !empty && ((state == FORCE_DRAIN) || !core_win);
    assign push       = !rst && !full && mu_valid && (mu_rd != '0);
    assign issue_fire = !rst && issue_valid && !busy[issue_rd] && (issue_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        state_next  = NORMAL;
        starve_next = '0;
        if (state == NORMAL && !empty && core_win) begin
            if (starve_cnt == CW'(STARVE_LIMIT - 1))
                state_next = FORCE_DRAIN;
            else
                starve_next = starve_cnt + CW'(1);
        end
    end

    always_comb begin
        wb_stall     = 1'b0;
        hazard_stall = 1'b0;
        issue_ready  = 1'b0;
        mu_ready     = 1'b0;
        RegWrite     = 1'b0;
        w_rg         = '0;
        w_data       = '0;
        if (!rst) begin
            wb_stall     = (state == FORCE_DRAIN);
            hazard_stall = busy[rs1] || busy[rs2] || (core_we && busy[core_rd]);
            issue_ready  = !busy[issue_rd];
            mu_ready     = !full;
            if (state == NORMAL && core_win) begin
                RegWrite = 1'b1;
                w_rg     = core_rd;
                w_data   = core_wdata;
            end else if (pop) begin
                RegWrite = 1'b1;
                w_rg     = head_rd;
                w_data   = head_data;
            end
        end
    end

    // Clear before set so a same-cycle issue to the retiring rd keeps it busy.
    always_comb begin
        busy_next = busy;
        if (pop)
            busy_next[head_rd] = 1'b0;
        if (issue_fire)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= '0;
        end else begin
            busy <= busy_next;
            if (push) begin
                fifo_rd[wr_ptr]   <= mu_rd;
                fifo_data[wr_ptr] <= mu_wdata;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW + 1)'(1);
            else if (pop && !push)
                count <= count - (PW + 1)'(1);
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised + directed bench for rf_wb_arbiter against a queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int DW = 32, RL = 5, DEPTH = 2, LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst, core_we, issue_valid, mu_valid;
    logic [RL-1:0] core_rd, rs1, rs2, issue_rd, mu_rd;
    logic [DW-1:0] core_wdata, mu_wdata;
    logic          wb_stall, hazard_stall, issue_ready, mu_ready, RegWrite;
    logic [RL-1:0] w_rg;
    logic [DW-1:0] w_data;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .REG_DATA_WIDTH(DW), .REG_CODE_LENGTH(RL), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
        .rs1(rs1), .rs2(rs2), .wb_stall(wb_stall), .hazard_stall(hazard_stall),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .mu_valid(mu_valid), .mu_rd(mu_rd), .mu_wdata(mu_wdata), .mu_ready(mu_ready),
        .RegWrite(RegWrite), .w_rg(w_rg), .w_data(w_data)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [RL-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   mbusy[32];
    int   starve = 0;
    bit   drain  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a posedge with inputs driven; checks mid-cycle, updates model at next edge.
    task automatic step();
        bit e_we, e_ws, e_hz, e_ir, e_mr, full, popped, core_won, nonempty;
        logic [RL-1:0] e_rg;
        logic [DW-1:0] e_dat;
        e_we = 0; e_ws = 0; e_hz = 0; e_ir = 0; e_mr = 0;
        e_rg = '0; e_dat = '0; popped = 0; core_won = 0;
        full = (q.size() == DEPTH);
        nonempty = (q.size() > 0);
        if (!rst) begin
            e_ws = drain;
            e_hz = mbusy[rs1] | mbusy[rs2] | (core_we & mbusy[core_rd]);
            e_ir = !mbusy[issue_rd];
            e_mr = !full;
            if (!drain && core_we && core_rd != 0) begin
                e_we = 1; e_rg = core_rd; e_dat = core_wdata; core_won = 1;
            end else if (nonempty) begin
                e_we = 1; e_rg = q[0].rd; e_dat = q[0].data; popped = 1;
            end
        end
        #3;
        check("RegWrite", 32'(RegWrite), 32'(e_we));
        check("w_rg", 32'(w_rg), 32'(e_rg));
        check("w_data", w_data, e_dat);
        check("wb_stall", 32'(wb_stall), 32'(e_ws));
        check("hazard_stall", 32'(hazard_stall), 32'(e_hz));
        check("issue_ready", 32'(issue_ready), 32'(e_ir));
        check("mu_ready", 32'(mu_ready), 32'(e_mr));
        @(posedge clk);
        if (rst) begin
            q.delete();
            foreach (mbusy[i]) mbusy[i] = 0;
            starve = 0;
            drain  = 0;
        end else begin
            if (popped) begin
                mbusy[q[0].rd] = 0;
                void'(q.pop_front());
            end
            if (issue_valid && e_ir && issue_rd != 0) mbusy[issue_rd] = 1;
            if (mu_valid && !full && mu_rd != 0) q.push_back('{rd: mu_rd, data: mu_wdata});
            if (drain) begin
                drain = 0; starve = 0;
            end else if (nonempty && core_won) begin
                starve++;
                if (starve == LIMIT) begin
                    drain = 1; starve = 0;
                end
            end else begin
                starve = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        core_we = 0; core_rd = '0; core_wdata = '0; rs1 = '0; rs2 = '0;
        issue_valid = 0; issue_rd = '0; mu_valid = 0; mu_rd = '0; mu_wdata = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #1;
        step(); step();
        rst = 0;
        step();

        // core write passes straight through
        core_we = 1; core_rd = 5'd5; core_wdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();

        // issue rd7, observe hazard, return result, busy clears after RF write
        issue_valid = 1; issue_rd = 5'd7;
        step();
        issue_valid = 0; rs1 = 5'd7;
        step();
        mu_valid = 1; mu_rd = 5'd7; mu_wdata = 32'h1234;
        step();
        mu_valid = 0;
        step(); step();
        idle_inputs();

        // starvation: core writes every cycle while rd3/rd4 sit in the FIFO
        core_we = 1; core_rd = 5'd1; core_wdata = 32'hC0DE;
        issue_valid = 1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd4;
        mu_valid = 1; mu_rd = 5'd3; mu_wdata = 32'h33;
        step();
        issue_valid = 0;
        mu_rd = 5'd4; mu_wdata = 32'h44;
        step();
        mu_rd = 5'd6; mu_wdata = 32'h66;
        step();
        mu_valid = 0;
        for (int i = 0; i < 14; i++) begin
            core_wdata = 32'(i);
            step();
        end
        idle_inputs();

        // rd0 result discarded; core_rd=0 lets the FIFO head through
        mu_valid = 1; mu_rd = '0; mu_wdata = 32'hBAD;
        step();
        core_we = 1; core_rd = 5'd2; mu_rd = 5'd9; mu_wdata = 32'h99;
        step();
        mu_valid = 0; core_rd = '0; core_wdata = 32'h5555;
        step();
        idle_inputs();

        // reset with full FIFO and busy bits
        core_we = 1; core_rd = 5'd1;
        issue_valid = 1; issue_rd = 5'd10; mu_valid = 1; mu_rd = 5'd11; mu_wdata = 32'hAA;
        step();
        issue_rd = 5'd12; mu_rd = 5'd12; mu_wdata = 32'hBB;
        step();
        idle_inputs();
        rs1 = 5'd10; rs2 = 5'd12;
        rst = 1;
        step();
        rst = 0;
        step(); step();
        idle_inputs();

        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 79) == 0);
            core_we     = ($urandom_range(0, 3) != 0);
            core_rd     = RL'($urandom_range(0, 7));
            core_wdata  = $urandom;
            rs1         = RL'($urandom_range(0, 15));
            rs2         = RL'($urandom_range(0, 15));
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = RL'($urandom_range(0, 15));
            mu_valid    = ($urandom_range(0, 1) == 0);
            mu_rd       = RL'($urandom_range(0, 15));
            mu_wdata    = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
